// File: rtl/spi_cmd_parser.sv
// SPI command parser: opcode byte + fixed-length payload -> one wide storage command -> status byte.
// Optional trailing XOR checksum byte is enabled by defining SPI_CMD_CHECKSUM_EN.
//
// state     | meaning
// IDLE      | waiting for an opcode byte
// PAYLOAD   | shifting in payload bytes, counter counts down to zero
// CHK       | waiting for checksum byte (SPI_CMD_CHECKSUM_EN only)
// ISSUE     | command presented to storage until cmd_ready
// WAIT      | waiting for storage status pulse
// REPORT    | status byte presented to SPI until tx_ready
// DISCARD   | dropping bytes of a bad frame until the next frame_start
module spi_cmd_parser #(
  parameter int LEN_VERT = 12,
  parameter int LEN_TRI  = 6,
  parameter int LEN_INST = 50,
  parameter int LEN_UPD  = 51,
  parameter int MAX_LEN  = 51
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [3:0]           cmd_opcode,
  output logic [MAX_LEN*8-1:0] cmd_payload,
  input  logic                 st_valid,
  input  logic [3:0]           st_code,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int PW = MAX_LEN * 8;

  localparam logic [3:0] OP_WIPE_ALL       = 4'h0;
  localparam logic [3:0] OP_CREATE_VERT    = 4'h1;
  localparam logic [3:0] OP_CREATE_TRI     = 4'h2;
  localparam logic [3:0] OP_CREATE_INST    = 4'h3;
  localparam logic [3:0] OP_UPDATE_INST    = 4'h4;
  localparam logic [3:0] ST_INVALID_DATA   = 4'h0;
  localparam logic [3:0] ST_INVALID_OPCODE = 4'h4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_ISSUE,
    S_WAIT,
    S_REPORT,
    S_DISCARD
`ifdef SPI_CMD_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t          state;
  logic            live;
  logic            inval;
  logic [CW-1:0]   cnt;
  logic [3:0]      opcode;
  logic [PW-1:0]   payload;
  logic            in_parse;
  logic            take;

  function automatic logic [CW-1:0] len_of(input logic [3:0] op);
    case (op)
      OP_CREATE_VERT: return CW'(LEN_VERT);
      OP_CREATE_TRI:  return CW'(LEN_TRI);
      OP_CREATE_INST: return CW'(LEN_INST);
      OP_UPDATE_INST: return CW'(LEN_UPD);
      default:        return '0;
    endcase
  endfunction

`ifdef SPI_CMD_CHECKSUM_EN
  logic [7:0] chk;
  assign in_parse = (state == S_PAYLOAD) || (state == S_CHK);
`else
  assign in_parse = (state == S_PAYLOAD);
`endif

  // A short-frame abort refuses the coincident byte so it survives as the next opcode.
  assign rx_ready = live && ((state == S_IDLE) || (state == S_DISCARD) ||
                             (in_parse && !frame_start));
  assign take        = rx_valid && rx_ready;
  assign cmd_opcode  = opcode;
  assign cmd_payload = payload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      live      <= 1'b0;
      inval     <= 1'b0;
      cnt       <= '0;
      opcode    <= '0;
      payload   <= '0;
      cmd_valid <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      live <= 1'b1;
      case (state)
        S_IDLE, S_DISCARD: begin
          if (frame_start) begin
            cnt   <= '0;
            state <= S_IDLE;
          end
          if ((state == S_IDLE || frame_start) && take) begin
            opcode  <= rx_data[7:4];
            payload <= '0;
            inval   <= 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
            chk     <= rx_data;
`endif
            if (rx_data[7:4] == OP_WIPE_ALL) begin
`ifdef SPI_CMD_CHECKSUM_EN
              state     <= S_CHK;
`else
              state     <= S_ISSUE;
              cmd_valid <= 1'b1;
`endif
            end else if (rx_data[7:4] <= OP_UPDATE_INST) begin
              state <= S_PAYLOAD;
              cnt   <= len_of(rx_data[7:4]);
            end else begin
              state    <= S_REPORT;
              inval    <= 1'b1;
              tx_valid <= 1'b1;
              tx_data  <= {rx_data[7:4], ST_INVALID_OPCODE};
            end
          end
        end
        S_PAYLOAD: begin
          if (frame_start) begin
            state    <= S_REPORT;
            cnt      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= {opcode, ST_INVALID_DATA};
          end else if (take) begin
            payload <= {payload[PW-9:0], rx_data};
            cnt     <= cnt - CW'(1);
`ifdef SPI_CMD_CHECKSUM_EN
            chk     <= chk ^ rx_data;
`endif
            if (cnt == CW'(1)) begin
`ifdef SPI_CMD_CHECKSUM_EN
              state     <= S_CHK;
`else
              state     <= S_ISSUE;
              cmd_valid <= 1'b1;
`endif
            end
          end
        end
`ifdef SPI_CMD_CHECKSUM_EN
        S_CHK: begin
          if (frame_start) begin
            state    <= S_REPORT;
            tx_valid <= 1'b1;
            tx_data  <= {opcode, ST_INVALID_DATA};
          end else if (take) begin
            if (rx_data == chk) begin
              state     <= S_ISSUE;
              cmd_valid <= 1'b1;
            end else begin
              state    <= S_REPORT;
              tx_valid <= 1'b1;
              tx_data  <= {opcode, ST_INVALID_DATA};
            end
          end
        end
`endif
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (st_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= {opcode, st_code};
            state    <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= inval ? S_DISCARD : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_cmd_parser.md
Name: spi_cmd_parser

Overview:
- Sits between the SPI slave byte interface and the scene storage block (vertex/triangle/instance buffers).
- Assembles an opcode byte plus a fixed-length payload into one wide command, hands it to storage, waits for storage's 4-bit status, then returns a status byte for SPI transmission.
- Opcode and status encodings are the codebase's opcode_defs and status_defs values.

Parameters:
- LEN_VERT, 12, payload bytes for OP_CREATE_VERT (3 x 32-bit coordinates)
- LEN_TRI, 6, payload bytes for OP_CREATE_TRI (3 x 16-bit vertex indices)
- LEN_INST, 50, payload bytes for OP_CREATE_INST (400-bit inst_t)
- LEN_UPD, 51, payload bytes for OP_UPDATE_INST (8-bit instance id, then 400-bit inst_t)
- MAX_LEN, 51, payload register size in bytes; must be at least every LEN_*

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse when SPI chip-select asserts
- rx_valid  in  1  received byte valid
- rx_data  in  8  received byte
- rx_ready  out  1  parser accepts rx_data
- cmd_valid  out  1  command available to storage
- cmd_ready  in  1  storage accepts command
- cmd_opcode  out  4  opcode_defs value
- cmd_payload  out  MAX_LEN*8  payload, right-aligned, unused MSBs zero
- st_valid  in  1  storage status valid (single-cycle pulse)
- st_code  in  4  status_defs value
- tx_valid  out  1  status byte available
- tx_ready  in  1  SPI slave takes status byte
- tx_data  out  8  {opcode[3:0], status[3:0]}

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, payload register 0.
- Handshakes: an rx byte is accepted on rx_valid&rx_ready; a command transfers on cmd_valid&cmd_ready; a status byte transfers on tx_valid&tx_ready.
- rx_ready is 1 only in IDLE, PAYLOAD, DISCARD and CHK; it is 0 in ISSUE, WAIT and REPORT, so incoming bytes are back-pressured there.
- IDLE:
  - Accepted byte sets opcode = rx_data[7:4]; rx_data[3:0] is ignored. Payload register clears.
  - Opcode 0000 (WIPE_ALL, length 0) -> ISSUE.
  - Opcodes 0001-0100 -> PAYLOAD; counter loads the opcode's LEN_* value.
  - Opcode 0101 or above -> REPORT with INVALID_OPCODE, then DISCARD.
- PAYLOAD:
  - Each accepted byte shifts in: payload <= {payload[MAX_LEN*8-9:0], rx_data}. The first byte ends up most significant.
  - Counter decrements on each byte. When the byte that brings the counter to 0 is accepted, go to ISSUE (or CHK when the optional feature is enabled).
  - cmd_valid rises the cycle after that last byte.
- ISSUE: cmd_valid=1; cmd_opcode and cmd_payload are held stable until cmd_ready. On transfer -> WAIT.
- WAIT: first st_valid latches st_code -> REPORT. st_valid in any other state is ignored.
- REPORT: tx_valid=1 and tx_data is held stable until tx_ready. On transfer -> IDLE, or -> DISCARD if the command was an invalid opcode.
- DISCARD: accepts and drops bytes until frame_start -> IDLE.
- frame_start in IDLE or DISCARD: return to IDLE and clear the counter.
- frame_start in PAYLOAD (short frame): abort the parse, go to REPORT with INVALID_DATA, then IDLE.
- frame_start in ISSUE, WAIT or REPORT: ignored; the in-flight command always completes.
- frame_start and rx_valid in the same cycle: frame_start is processed first, and the byte is treated as the new opcode byte.
- Reset mid-operation: immediate return to IDLE. Any pending command or status is dropped with no output.

Optional Feature:
- Macro: SPI_CMD_CHECKSUM_EN.
- Enabled:
  - After the last payload byte, state CHK expects one extra byte equal to the XOR of the opcode byte and all payload bytes. For WIPE_ALL this is the opcode byte itself.
  - Match -> ISSUE.
  - Mismatch -> REPORT with INVALID_DATA; storage sees no command.
- Disabled: CHK state absent, no trailing byte expected.

Test Plan:
- Reset, then bytes 0x00 -> cmd_valid with cmd_opcode=0; hold cmd_ready low 3 cycles (outputs stable); then st_code=0001 -> tx_data=0x01.
- Opcode 0x10 + 12 bytes 0x01..0x0C -> cmd_payload[95:0]=0x0102030405060708090A0B0C, upper bits 0; cmd_valid asserted the cycle after byte 12; status 0010 -> tx_data=0x12.
- Byte 0x70 -> tx_data=0x74 (INVALID_OPCODE); following bytes dropped; after frame_start, 0x20 + 6 bytes -> cmd_opcode=2.
- 0x30 + 20 bytes, then frame_start -> no cmd_valid, tx_data=0x30 (INVALID_DATA), parser back in IDLE.
- rx_valid held high during WAIT -> rx_ready=0 and no byte is consumed until REPORT completes; asserting rst in WAIT -> all outputs 0 next cycle.
- SPI_CMD_CHECKSUM_EN: 0x20,01,02,03,04,05,06 with checksum 0x27 -> command issued; with checksum 0x00 -> no command, tx_data=0x20.
